// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW       = 32;
  localparam int unsigned DefDataW       = 32;
  localparam int unsigned DefWaitStates  = 1;
  localparam int unsigned DefStarveLimit = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } gnt_e;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory port arbiter: data has priority over fetch.
// With MEM_ARB_FAIRNESS_EN defined, a starved fetch overrides that priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
`ifdef MEM_ARB_FAIRNESS_EN
  input  logic starved,
`endif
  output gnt_e gnt
);

  // Pick the winner among the pending requests.
  always_comb begin
    gnt = dm_req ? GNT_DM : GNT_IF;
`ifdef MEM_ARB_FAIRNESS_EN
    if (if_req && dm_req && starved) begin
      gnt = GNT_IF;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// One access at a time, WAIT_STATES extra access cycles, registered rdata and
// one-cycle valid pulses. Optional fetch anti-starvation: MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned WAIT_STATES  = DefWaitStates,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_MR,
  output logic              mem_MW,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = cnt_width(WAIT_STATES);

  arb_state_e        state_q, state_d;
  gnt_e              gnt_q, gnt_d, pick_gnt;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned StreakW = cnt_width(STARVE_LIMIT);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               starved;

  assign starved = (streak_q == StreakW'(STARVE_LIMIT));
`endif

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .dm_req  (dm_req),
`ifdef MEM_ARB_FAIRNESS_EN
    .starved (starved),
`endif
    .gnt     (pick_gnt)
  );

  // Next-state logic: grant in IDLE, count wait states in ACCESS, pulse in RESP.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
    streak_d   = streak_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          gnt_d   = pick_gnt;
          wdata_d = dm_wdata;
          cnt_d   = CntW'(WAIT_STATES);
          state_d = ACCESS;
          if (pick_gnt == GNT_DM) begin
            addr_d = dm_addr;
            we_d   = dm_we;
          end else begin
            addr_d = if_addr;
            we_d   = 1'b0;
          end
`ifdef MEM_ARB_FAIRNESS_EN
          // Count data grants that bypassed a waiting fetch; saturate, never wrap.
          if (pick_gnt == GNT_IF || !if_req) begin
            streak_d = '0;
          end else if (streak_q != '1) begin
            streak_d = streak_q + StreakW'(1);
          end
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (gnt_q == GNT_IF) begin
            if_valid_d = 1'b1;
            if (!we_q) if_rdata_d = mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      streak_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
`ifdef MEM_ARB_FAIRNESS_EN
      streak_q   <= streak_d;
`endif
    end
  end

  // Memory strobes: MR spans the whole read access, MW only on its last cycle.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_MR    = (state_q == ACCESS) && !we_q;
    mem_MW    = (state_q == ACCESS) && we_q && (cnt_q == '0);
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, a cycle-level transaction model
// checked every cycle on the main DUT (WAIT_STATES=1), plus a WAIT_STATES=0 DUT.
module tb_mem_port_arbiter;

  localparam int unsigned WS    = 1;
  localparam int          LIMIT = 2;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, stall_if, stall_mem, mem_MR, mem_MW;

  // Second instance with zero wait states, read-only traffic.
  logic        d0_dm_req;
  logic [31:0] d0_dm_addr;
  logic [31:0] d0_if_rdata, d0_dm_rdata, d0_mem_addr, d0_mem_wdata, d0_mem_rdata;
  logic        d0_if_valid, d0_dm_valid, d0_stall_if, d0_stall_mem, d0_mem_MR, d0_mem_MW;

  logic [31:0] mem [256];

  assign mem_rdata    = mem[mem_addr[9:2]];
  assign d0_mem_rdata = mem[d0_mem_addr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, 8'(i)};
      mem[4]  <= 32'hCAFE1234;
      mem[12] <= 32'h11112222;
    end else if (mem_MW) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS), .STARVE_LIMIT(LIMIT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_MR(mem_MR), .mem_MW(mem_MW),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .STARVE_LIMIT(LIMIT)
  ) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(d0_if_rdata), .if_valid(d0_if_valid),
    .dm_req(d0_dm_req), .dm_we(1'b0), .dm_addr(d0_dm_addr), .dm_wdata(32'h0),
    .dm_rdata(d0_dm_rdata), .dm_valid(d0_dm_valid),
    .stall_if(d0_stall_if), .stall_mem(d0_stall_mem),
    .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata), .mem_MR(d0_mem_MR),
    .mem_MW(d0_mem_MW), .mem_rdata(d0_mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // A grant sampled in cycle g occupies the memory in cycles g+1..g+1+WS,
  // valid shows in g+2+WS, and the port is free again from g+3+WS.
  int          cyc = 0;
  int          g = 0;
  bit          mdl_on = 1'b0;
  bit          busy = 1'b0;
  bit          m_if = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] e_if_rdata = '0, e_dm_rdata = '0;
  int          streak = 0;

  initial begin
    forever begin
      bit take_if;
      @(posedge clk);
      if (!rst_n) begin
        busy       = 1'b0;
        e_if_rdata = '0;
        e_dm_rdata = '0;
        streak     = 0;
        mdl_on     = 1'b1;
      end else if (mdl_on) begin
        if (busy) begin
          if (cyc == g + 1 + int'(WS) && !m_we) begin
            if (m_if) e_if_rdata = mem[m_addr[9:2]];
            else      e_dm_rdata = mem[m_addr[9:2]];
          end
          if (cyc == g + 2 + int'(WS)) busy = 1'b0;
        end else if (if_req || dm_req) begin
          take_if = if_req && (!dm_req || (FAIR && streak == LIMIT));
          busy    = 1'b1;
          g       = cyc;
          m_if    = take_if;
          m_we    = take_if ? 1'b0 : dm_we;
          m_addr  = take_if ? if_addr : dm_addr;
          m_wdata = dm_wdata;
          streak  = (take_if || !if_req) ? 0 : streak + 1;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of the main DUT against the model.
  initial begin
    forever begin
      bit acc, resp, e_ifv, e_dmv, e_mw;
      @(negedge clk);
      if (mdl_on) begin
        acc   = busy && cyc >= g + 1 && cyc <= g + 1 + int'(WS);
        resp  = busy && cyc == g + 2 + int'(WS);
        e_ifv = resp && m_if;
        e_dmv = resp && !m_if;
        e_mw  = acc && m_we && cyc == g + 1 + int'(WS);
        chk("mdl_mem_MR", {31'b0, mem_MR}, {31'b0, acc && !m_we});
        chk("mdl_mem_MW", {31'b0, mem_MW}, {31'b0, e_mw});
        chk("mdl_if_valid", {31'b0, if_valid}, {31'b0, e_ifv});
        chk("mdl_dm_valid", {31'b0, dm_valid}, {31'b0, e_dmv});
        chk("mdl_if_rdata", if_rdata, e_if_rdata);
        chk("mdl_dm_rdata", dm_rdata, e_dm_rdata);
        chk("mdl_stall_if", {31'b0, stall_if}, {31'b0, if_req && !e_ifv});
        chk("mdl_stall_mem", {31'b0, stall_mem}, {31'b0, dm_req && !e_dmv});
        if (acc) chk("mdl_mem_addr", mem_addr, m_addr);
        if (e_mw) chk("mdl_mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          r_if_k, r_dm_k, r_mr, r_mw, r_mw_k, r_stm;
  logic [31:0] r_if_data, r_dm_data;

  // Starts at the drive slot of cycle t (k=0); drops each request on its valid.
  task automatic serve(input bit do_if, input bit do_dm, input bit we,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] da_late, input logic [31:0] wd);
    bit if_pend, dm_pend;
    if_pend = do_if;
    dm_pend = do_dm;
    r_if_k = -1; r_dm_k = -1; r_mr = 0; r_mw = 0; r_mw_k = -1; r_stm = 0;
    r_if_data = 'x; r_dm_data = 'x;
    if_req = do_if; if_addr = ia;
    dm_req = do_dm; dm_we = we; dm_addr = da; dm_wdata = wd;
    for (int k = 0; k < 30 && (if_pend || dm_pend); k++) begin
      if (k == 1) dm_addr = da_late;
      @(negedge clk);
      if (mem_MR) r_mr++;
      if (mem_MW) begin r_mw++; r_mw_k = k; end
      if (stall_mem) r_stm++;
      if (dm_valid && dm_pend) begin
        r_dm_k = k; r_dm_data = dm_rdata; dm_pend = 1'b0;
        #1 dm_req = 1'b0;
      end else if (if_valid && if_pend) begin
        r_if_k = k; r_if_data = if_rdata; if_pend = 1'b0;
        #1 if_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("serve_completed", {31'b0, if_pend | dm_pend}, 32'd0);
  endtask

  initial begin
    int ndm, ifseen, nv, k0, mr0;
    logic [31:0] d0_data;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
    d0_dm_req = 0; d0_dm_addr = 0;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_dm_valid", {31'b0, dm_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_mem_MR", {31'b0, mem_MR}, 32'd0);
    chk("rst_mem_MW", {31'b0, mem_MW}, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read 0x10; address changed while stalled must be ignored.
    serve(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h30, 32'h0);
    chk("rd_latency", r_dm_k, 32'd3);
    chk("rd_data", r_dm_data, 32'hCAFE1234);
    chk("rd_mr_cycles", r_mr, 32'd2);
    chk("rd_stall_cycles", r_stm, 32'd3);

    // Write 0xBEEF to 0x20, then read it back.
    serve(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h20, 32'h0000BEEF);
    chk("wr_mw_cycles", r_mw, 32'd1);
    chk("wr_mw_at", r_mw_k, 32'd2);
    chk("wr_latency", r_dm_k, 32'd3);
    chk("wr_rdata_kept", r_dm_data, 32'hCAFE1234);
    serve(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h20, 32'h0);
    chk("rdback_data", r_dm_data, 32'h0000BEEF);

    // Both requests together: data first, fetch right after.
    serve(1'b1, 1'b1, 1'b0, 32'h30, 32'h10, 32'h10, 32'h0);
    chk("both_dm_k", r_dm_k, 32'd3);
    chk("both_if_k", r_if_k, 32'd7);
    chk("both_if_data", r_if_data, 32'h11112222);
    chk("both_mr_cycles", r_mr, 32'd4);

    // Data requests kept up continuously with a fetch pending.
    ndm = 0; ifseen = 0;
    if_req = 1; if_addr = 32'h30; dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    for (int k = 0; k < 40 && ifseen == 0; k++) begin
      @(negedge clk);
      if (dm_valid) ndm++;
      if (if_valid) ifseen = 1;
      @(posedge clk); #1;
    end
    if_req = 0; dm_req = 0;
    if (FAIR) begin
      chk("fair_dm_grants", ndm, 32'd2);
      chk("fair_if_served", ifseen, 32'd1);
    end else begin
      chk("strict_dm_grants", ndm, 32'd10);
      chk("strict_if_starved", ifseen, 32'd0);
    end
    repeat (4) begin @(posedge clk); #1; end

    // Reset in the middle of an access.
    dm_req = 1; dm_we = 0; dm_addr = 32'h30;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_in_access", {31'b0, mem_MR}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; dm_req = 0;
    @(negedge clk);
    chk("mid_mem_MR", {31'b0, mem_MR}, 32'd0);
    chk("mid_mem_MW", {31'b0, mem_MW}, 32'd0);
    chk("mid_dm_valid", {31'b0, dm_valid}, 32'd0);
    chk("mid_dm_rdata", dm_rdata, 32'd0);
    chk("mid_if_rdata", if_rdata, 32'd0);
    nv = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (dm_valid || if_valid) nv++;
    end
    chk("mid_no_valid", nv, 32'd0);
    @(posedge clk); #1;

    // Zero wait states: two-cycle read latency, single MR cycle.
    k0 = -1; mr0 = 0; d0_data = 'x;
    d0_dm_req = 1; d0_dm_addr = 32'h10;
    for (int k = 0; k < 10 && k0 < 0; k++) begin
      @(negedge clk);
      if (d0_mem_MR) mr0++;
      if (d0_dm_valid) begin
        k0 = k; d0_data = d0_dm_rdata;
        #1 d0_dm_req = 0;
      end
      @(posedge clk); #1;
    end
    chk("ws0_latency", k0, 32'd2);
    chk("ws0_mr_cycles", mr0, 32'd1);
    chk("ws0_data", d0_data, 32'hCAFE1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-ported `Memory` shared by instruction fetch and the memory stage. Grants one access at a time and holds the memory strobes for a configurable number of wait states. Returns read data with a one-cycle valid pulse and drives the pipeline stall lines. Sits between the IF/MEM stages and the `Memory` instance, which it drives in place of direct stage wiring.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, memory data width
- `WAIT_STATES`, 1, extra cycles an access occupies; minimum 0
- `STARVE_LIMIT`, 4, consecutive data grants allowed while a fetch is pending (fairness build only)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `if_req`  in  1  fetch request; level, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, registered
- `if_valid`  out  1  one-cycle completion pulse for fetch
- `dm_req`  in  1  data request; level, held until `dm_valid`
- `dm_we`  in  1  1 = write (MW), 0 = read (MR)
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  write data
- `dm_rdata`  out  DATA_W  read word, registered
- `dm_valid`  out  1  one-cycle completion pulse for data
- `stall_if`  out  1  `if_req & ~if_valid`
- `stall_mem`  out  1  `dm_req & ~dm_valid`
- `mem_addr`  out  ADDR_W  to `Memory.Address`
- `mem_wdata`  out  DATA_W  to `Memory.Write_Data`
- `mem_MR`  out  1  to `Memory.MR`
- `mem_MW`  out  1  to `Memory.MW`
- `mem_rdata`  in  DATA_W  from `Memory.Read_Data`; combinational read

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - no request: stay.
  - otherwise latch grant, address, write data and `dm_we`; load wait counter with `WAIT_STATES`; go to ACCESS.
  - priority: data over fetch.
- ACCESS:
  - `mem_addr`/`mem_wdata` driven from latched values.
  - `mem_MR` high for the whole state on reads.
  - `mem_MW` high only when counter = 0, giving exactly one write edge.
  - Counter decrements each cycle. At 0, capture `mem_rdata` into the granted port's rdata register (reads only) and go to RESP.
- RESP: assert the granted port's valid for one cycle, then go to IDLE. Requests are ignored in RESP.
- Writes still pulse `dm_valid`; `dm_rdata` keeps its previous value.
- Both requests in IDLE: data wins; fetch stays stalled and is served next.
- Requester changes address while stalled: no effect; the latched values are used.
- Reset (any state, including mid-ACCESS): next state IDLE; in-flight access is discarded with no valid pulse.
- Reset values: all strobes 0, valids 0, rdata registers 0, counters 0.

## Timing
- Request sampled in IDLE at cycle t.
- ACCESS occupies cycles t+1 … t+1+WAIT_STATES.
- Valid is high at cycle t+2+WAIT_STATES, so latency = WAIT_STATES+2 cycles.
- Back-to-back requests: a new grant is possible at t+3+WAIT_STATES.
- Stall outputs are combinational from `*_req` and the registered valids; they drop in the valid cycle.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - a streak counter increments on each data grant made while `if_req` is high.
  - when it equals `STARVE_LIMIT` and both requests are pending, fetch is granted instead.
  - the counter clears on any fetch grant or when `if_req` is low at a data grant.
- Undefined: strict data priority; no streak counter is synthesised.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/ACCESS/RESP), grant enum (GNT_IF/GNT_DM), default parameter constants.
- Sub-module `mem_arb_pick`: combinational grant selection (priority plus optional fairness override). Keeps the FSM free of policy.

## Test plan
- WAIT_STATES=1, `dm_req` read of addr 0x10 (mem holds 0xCAFE1234):
  - `dm_valid` at t+3 with `dm_rdata`=0xCAFE1234.
  - `stall_mem` high t..t+2.
- `dm_we`=1 write 0x0000BEEF to 0x20: `mem_MW` high exactly one cycle (t+2); `dm_valid` at t+3; subsequent read returns 0x0000BEEF.
- `if_req` and `dm_req` both raised at t:
  - data served first, valid at t+3.
  - fetch granted at t+4, `if_valid` at t+7.
- Fairness build, STARVE_LIMIT=2, `dm_req` continuously re-raised with `if_req` held: third grant goes to fetch; without the macro, fetch never completes.
- `rst_n` low for one cycle during ACCESS: FSM IDLE next cycle; `mem_MR`/`mem_MW`=0; no valid pulse; outputs at reset values.
- WAIT_STATES=0: read latency 2 cycles; `mem_MR` high exactly one cycle.
